// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Three-button synchronizer, debouncer, press/long-press detector
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DB_CYCLES = 500000,
    parameter int LP_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    output logic [2:0] level,
    output logic [2:0] press,
    output logic [2:0] long_press,
    output logic       busy
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int LP_W = (LP_CYCLES > 2) ? $clog2(LP_CYCLES) : 1;

    localparam logic [DB_W-1:0] c_DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [LP_W-1:0] c_LP_FIRE  = LP_W'(LP_CYCLES - 2);
    localparam logic [LP_W-1:0] c_LP_LAST  = LP_W'(LP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [2:0] w_rise;
    logic [2:0] w_level_next;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bit
            logic            r_s1;
            logic            r_s2;
            logic            r_lvl;
            logic            r_lp;
            logic [DB_W-1:0] r_db_cnt;
            logic [LP_W-1:0] r_hold;
            state_t          r_state;
            logic            w_diff;
            logic            w_accept;
            logic            w_fall;

            assign w_diff            = r_s2 ^ r_lvl;
            assign w_accept          = w_diff && (r_db_cnt == c_DB_LAST);
            assign w_rise[gi]        = w_accept && r_s2;
            assign w_fall            = w_accept && !r_s2;
            assign w_level_next[gi]  = w_accept ? r_s2 : r_lvl;
            assign level[gi]         = r_lvl;
            assign long_press[gi]    = r_lp;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_lvl    <= 1'b0;
                    r_lp     <= 1'b0;
                    r_db_cnt <= '0;
                    r_hold   <= '0;
                    r_state  <= ST_IDLE;
                end else begin
                    r_s1 <= btn[gi];
                    r_s2 <= r_s1;

                    // The counter only ever reaches DB-1, where the level is accepted.
                    if (!w_diff) begin
                        r_db_cnt <= '0;
                    end else if (w_accept) begin
                        r_lvl    <= r_s2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end

                    r_lp <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            r_hold <= '0;
                            if (w_rise[gi]) begin
                                r_state <= ST_PRESSED;
                            end
                        end
                        ST_PRESSED: begin
                            if (w_fall) begin
                                r_state <= ST_IDLE;
                                r_hold  <= '0;
                            end else if (r_hold == c_LP_FIRE) begin
                                // Hold reaches LP-1 on this edge: fire and park saturated.
                                r_lp    <= 1'b1;
                                r_hold  <= c_LP_LAST;
                                r_state <= ST_HELD;
                            end else begin
                                r_hold <= r_hold + LP_W'(1);
                            end
                        end
                        ST_HELD: begin
                            if (w_fall) begin
                                r_state <= ST_IDLE;
                                r_hold  <= '0;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_hold  <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Simultaneous requests: highest index wins, the rest are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            press <= 3'b000;
            busy  <= 1'b0;
        end else begin
            if (w_rise[2]) begin
                press <= 3'b100;
            end else if (w_rise[1]) begin
                press <= 3'b010;
            end else if (w_rise[0]) begin
                press <= 3'b001;
            end else begin
                press <= 3'b000;
            end
            busy <= |w_level_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 500000: consecutive stable synchronized samples required to accept a level change (5 ms at 100 MHz); legal range 2 or more.
REQ-002 Parameter LP_CYCLES, default 100000000: debounced-high cycles before a long-press event (1 s at 100 MHz); legal range 2 or more.
REQ-003 Port clk, input, 1: single system clock; all logic is clocked on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port btn, input, 3: raw asynchronous buttons; bit 0 start, bit 1 stop, bit 2 restart; active-high.
REQ-006 Port level, output, 3: debounced button levels.
REQ-007 Port press, output, 3: one-cycle pulse per accepted press, after arbitration.
REQ-008 Port long_press, output, 3: one-cycle pulse when a press has been held LP_CYCLES.
REQ-009 Port busy, output, 1: high while any debounced level is high.

Function
REQ-010 Each bit SHALL pass through a private 2-flop synchronizer (s1, s2); no raw btn bit reaches other logic.
REQ-011 Per bit, the debounce counter SHALL reset to 0 in any cycle where s2 equals level.
REQ-012 When s2 differs from level and the counter is below DB_CYCLES-1, the counter SHALL increment.
REQ-013 When s2 differs from level and the counter equals DB_CYCLES-1, level SHALL take s2 and the counter SHALL return to 0.
REQ-014 Latency: if btn rises and stays stable before edge k, level SHALL first read 1 after edge k+DB_CYCLES+1; release latency SHALL be identical.
REQ-015 A glitch shorter than DB_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-016 Per-bit FSM states: IDLE, PRESSED, HELD.
REQ-017 IDLE to PRESSED on a level 0->1 edge; the raw press request SHALL be high on the same edge that level rises.
REQ-018 In PRESSED, a hold counter SHALL start at 0 and increment each cycle while level is 1.
REQ-019 In PRESSED, when the hold counter equals LP_CYCLES-1, long_press SHALL pulse for one cycle and the FSM SHALL move to HELD.
REQ-020 PRESSED or HELD to IDLE on a level 1->0 edge; the hold counter SHALL clear.
REQ-021 long_press SHALL pulse at most once per press, and never in HELD or IDLE.
REQ-022 Arbitration: if more than one raw press request occurs in the same cycle, only the highest index SHALL appear on press (restart over stop over start); the others SHALL be dropped, not deferred.
REQ-023 press SHALL be one-hot or zero in every cycle; long_press bits are independent and are not arbitrated.
REQ-024 All outputs SHALL be registered; press and long_press SHALL last exactly one cycle.
REQ-025 busy SHALL equal the OR of the level bits, registered.
REQ-026 Counter widths SHALL be sized from the parameters; counters SHALL saturate and never wrap.

Reset
REQ-027 With rst high at an edge, the following SHALL clear to 0: s1, s2, level, press, long_press, busy and all counters; every FSM SHALL return to IDLE.
REQ-028 rst SHALL override all other activity, including reset arriving mid-debounce or mid-hold.
REQ-029 A button held through the release of rst SHALL be treated as a fresh press: after DB_CYCLES+2 edges, level rises and press pulses.
REQ-030 No output SHALL pulse in the cycle rst is high or in the first cycle after it falls.

Verification (DB_CYCLES=4, LP_CYCLES=10)
REQ-031 Clean press: btn=001 is held from edge 0; level[0]=1 and press=001 after edge 5; press returns to 000 after edge 6; long_press=001 for one cycle after edge 14; level=0 six edges after release.
REQ-032 Glitch: btn[1] is high for 3 cycles, then low; level, press, long_press and busy all stay 0.
REQ-033 Simultaneous presses: btn goes 000->111 at once; press=100 for exactly one cycle; level=111; busy=1; long_press=111 in the same cycle.
REQ-034 Short press: btn[2] is high for 8 cycles; press=100 pulses once; long_press never asserts; the FSM is in IDLE after release latency.
REQ-035 Reset mid-hold: btn[0] is held and rst pulses 3 edges after press; all outputs are 0 during and after rst; press re-pulses DB_CYCLES+2 edges after rst falls; long_press is timed from the new press.
REQ-036 Bounce: btn[1] toggles every 2 cycles for 20 cycles, then goes stably high; exactly one press=010 occurs, 6 edges after stability.
